// File: rtl/ram4k_wr_buffer.sv
// Write-posting buffer in front of the 4K-word RAM: queues writes, drains one per cycle,
// forwards pending data to both read ports. Define WR_BUFFER_COALESCE_EN to merge same-address writes.
module ram4k_wr_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 12,
    parameter int DW    = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,        // active-low, asynchronous
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [AW-1:0]          in_addr_i,
    input  logic [DW-1:0]          in_data_i,
    input  logic                   hold_i,
    input  logic                   flush_i,
    output logic                   flush_done_o,
    output logic                   ram_wr_o,
    output logic [AW-1:0]          ram_wr_addr_o,
    output logic [DW-1:0]          ram_d_in_o,
    input  logic [AW-1:0]          rd_addr_a_i,
    input  logic [AW-1:0]          rd_addr_b_i,
    input  logic [DW-1:0]          ram_d_out_a_i,
    input  logic [DW-1:0]          ram_d_out_b_i,
    output logic [DW-1:0]          d_out_a_o,
    output logic [DW-1:0]          d_out_b_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [1:0]             state_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [AW-1:0] addr_mem_q [DEPTH];
    logic [DW-1:0] data_mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic          pop, push, alloc;

`ifdef WR_BUFFER_COALESCE_EN
    logic [DEPTH-1:0] occ;
    logic             coal_hit;
    logic [PW-1:0]    coal_idx;

    // A slot is occupied when its distance from the head is below the count.
    always_comb begin
        logic [PW-1:0] off;
        occ      = '0;
        coal_hit = 1'b0;
        coal_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off    = PW'(i) - head_q;
            occ[i] = (CW'(off) < count_q);
            if (occ[i] && !(pop && PW'(i) == head_q) && addr_mem_q[i] == in_addr_i) begin
                coal_hit = 1'b1;
                coal_idx = PW'(i);
            end
        end
    end

    assign in_ready_o = (state_q == ST_RUN) && (!full_o || coal_hit);
    assign alloc      = push && !coal_hit;
`else
    assign in_ready_o = (state_q == ST_RUN) && !full_o;
    assign alloc      = push;
`endif

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign state_o = state_q;

    assign pop  = !empty_o && !hold_i;
    assign push = in_valid_i && in_ready_o;

    assign ram_wr_o      = pop;
    assign ram_wr_addr_o = addr_mem_q[head_q];
    assign ram_d_in_o    = data_mem_q[head_q];
    assign flush_done_o  = (state_q == ST_DONE);

    assign count_d = count_q + CW'(alloc) - CW'(pop);
    assign head_d  = head_q + PW'(pop);
    assign tail_d  = tail_q + PW'(alloc);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (flush_i) state_d = (count_d == '0) ? ST_DONE : ST_FLUSH;
            ST_FLUSH: if (count_d == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // Oldest to youngest, so the youngest matching entry wins.
    always_comb begin
        logic [PW-1:0] idx;
        d_out_a_o = ram_d_out_a_i;
        d_out_b_o = ram_d_out_b_i;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (CW'(k) < count_q) begin
                if (addr_mem_q[idx] == rd_addr_a_i) d_out_a_o = data_mem_q[idx];
                if (addr_mem_q[idx] == rd_addr_b_i) d_out_b_o = data_mem_q[idx];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= ST_RUN;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    // Entry storage carries no reset; occupancy is tracked by count/head only.
    always_ff @(posedge clk_i) begin
        if (alloc) begin
            addr_mem_q[tail_q] <= in_addr_i;
            data_mem_q[tail_q] <= in_data_i;
        end
`ifdef WR_BUFFER_COALESCE_EN
        else if (push) begin
            data_mem_q[coal_idx] <= in_data_i;
        end
`endif
    end

endmodule

// File: tb/tb_ram4k_wr_buffer.sv
// Bench for ram4k_wr_buffer: queue-based reference model, directed scenarios and random traffic.
module tb_ram4k_wr_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 12;
    localparam int DW    = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid, in_ready, hold, flush, flush_done, ram_wr, empty, full;
    logic [AW-1:0] in_addr, ram_wr_addr, rd_addr_a, rd_addr_b;
    logic [DW-1:0] in_data, ram_d_in, ram_d_out_a, ram_d_out_b, d_out_a, d_out_b;
    logic [CW-1:0] count;
    logic [1:0]    state_dbg;

    always #5 clk = ~clk;

    ram4k_wr_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk_i(clk), .reset_i(reset_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_addr_i(in_addr), .in_data_i(in_data),
        .hold_i(hold), .flush_i(flush), .flush_done_o(flush_done),
        .ram_wr_o(ram_wr), .ram_wr_addr_o(ram_wr_addr), .ram_d_in_o(ram_d_in),
        .rd_addr_a_i(rd_addr_a), .rd_addr_b_i(rd_addr_b),
        .ram_d_out_a_i(ram_d_out_a), .ram_d_out_b_i(ram_d_out_b),
        .d_out_a_o(d_out_a), .d_out_b_o(d_out_b),
        .count_o(count), .empty_o(empty), .full_o(full), .state_o(state_dbg)
    );

    // Environment RAM written by the DUT; the model keeps its own copy.
    logic [DW-1:0] env_ram   [1 << AW];
    logic [DW-1:0] model_ram [1 << AW];
    assign ram_d_out_a = env_ram[rd_addr_a];
    assign ram_d_out_b = env_ram[rd_addr_b];
    always @(posedge clk) if (ram_wr) env_ram[ram_wr_addr] <= ram_d_in;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t q[$];
    int   phase;            // 0 running, 1 flushing, 2 flush complete
    logic exp_pop, exp_push;
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] fwd(input logic [AW-1:0] ra);
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].a == ra) return q[i].d;
        return model_ram[ra];
    endfunction

    task automatic model_check();
        int   sz;
        logic pop_n, hit, rdy;
        sz    = q.size();
        pop_n = (sz > 0) && !hold;
        hit   = 1'b0;
`ifdef WR_BUFFER_COALESCE_EN
        for (int i = (pop_n ? 1 : 0); i < sz; i++)
            if (q[i].a == in_addr) hit = 1'b1;
`endif
        rdy      = (phase == 0) && (sz < DEPTH || hit);
        exp_pop  = pop_n;
        exp_push = in_valid && rdy;
        chk("count", 32'(count), 32'(sz));
        chk("empty", 32'(empty), 32'(sz == 0));
        chk("full", 32'(full), 32'(sz == DEPTH));
        chk("in_ready", 32'(in_ready), 32'(rdy));
        chk("ram_wr", 32'(ram_wr), 32'(pop_n));
        chk("flush_done", 32'(flush_done), 32'(phase == 2));
        if (sz > 0) begin
            chk("ram_wr_addr", 32'(ram_wr_addr), 32'(q[0].a));
            chk("ram_d_in", 32'(ram_d_in), 32'(q[0].d));
        end
        chk("d_out_a", 32'(d_out_a), 32'(fwd(rd_addr_a)));
        chk("d_out_b", 32'(d_out_b), 32'(fwd(rd_addr_b)));
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic h, input logic f,
                         input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        in_valid  = v;
        in_addr   = a;
        in_data   = d;
        hold      = h;
        flush     = f;
        rd_addr_a = ra;
        rd_addr_b = rb;
        #1;
        model_check();
    endtask

    task automatic tick();
        int j;
        @(posedge clk);
        if (exp_pop) begin
            model_ram[q[0].a] = q[0].d;
            void'(q.pop_front());
        end
        if (exp_push) begin
            j = -1;
`ifdef WR_BUFFER_COALESCE_EN
            for (int i = 0; i < q.size(); i++) if (q[i].a == in_addr) j = i;
`endif
            if (j >= 0) q[j].d = in_data;
            else q.push_back('{a: in_addr, d: in_data});
        end
        if (phase == 0 && flush) phase = (q.size() == 0) ? 2 : 1;
        else if (phase == 1 && q.size() == 0) phase = 2;
        else if (phase == 2) phase = 0;
        @(negedge clk);
    endtask

    task automatic idle(input logic h);
        drive(1'b0, '0, '0, h, 1'b0, 12'h040, 12'h041);
    endtask

    initial begin
        logic [DW-1:0] rv;
        for (int i = 0; i < (1 << AW); i++) begin
            rv = DW'($urandom);
            env_ram[i]   = rv;
            model_ram[i] = rv;
        end
        phase    = 0;
        reset_n  = 1'b0;
        in_valid = 1'b0; in_addr = '0; in_data = '0; hold = 1'b0; flush = 1'b0;
        rd_addr_a = '0; rd_addr_b = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_ram_wr", 32'(ram_wr), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_flush_done", 32'(flush_done), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single write goes straight through.
        drive(1'b1, 12'h123, 16'hBEEF, 1'b0, 1'b0, 12'h123, 12'h124);
        tick();
        idle(1'b0);
        chk("t1_ram_wr", 32'(ram_wr), 1);
        chk("t1_addr", 32'(ram_wr_addr), 32'h123);
        chk("t1_data", 32'(ram_d_in), 32'hBEEF);
        chk("t1_count1", 32'(count), 1);
        tick();
        idle(1'b0);
        chk("t1_count0", 32'(count), 0);
        chk("t1_empty", 32'(empty), 1);
        tick();

        // Fill while held, stall a fifth request, then drain in order.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, AW'(i), DW'($urandom), 1'b1, 1'b0, AW'(i), 12'h040);
            tick();
        end
        drive(1'b1, 12'h004, 16'h5555, 1'b1, 1'b0, 12'h002, 12'h004);
        chk("t2_full", 32'(full), 1);
        chk("t2_in_ready", 32'(in_ready), 0);
        tick();
        chk("t2_count_stall", 32'(count), 4);
        for (int i = 0; i < 4; i++) begin
            idle(1'b0);
            chk("t2_drain_wr", 32'(ram_wr), 1);
            chk("t2_drain_addr", 32'(ram_wr_addr), 32'(i));
            tick();
        end
        idle(1'b0);
        chk("t2_empty", 32'(empty), 1);
        tick();

        // Duplicate addresses: youngest data forwards.
        drive(1'b1, 12'h0A0, 16'h1111, 1'b1, 1'b0, 12'h0A0, 12'h0A1);
        tick();
        drive(1'b1, 12'h0A0, 16'h2222, 1'b1, 1'b0, 12'h0A0, 12'h0A1);
        tick();
        drive(1'b0, '0, '0, 1'b1, 1'b0, 12'h0A0, 12'h0A1);
        chk("t3_fwd_a", 32'(d_out_a), 32'h2222);
        chk("t3_pass_b", 32'(d_out_b), 32'(ram_d_out_b));
`ifdef WR_BUFFER_COALESCE_EN
        chk("t3_count", 32'(count), 1);
`else
        chk("t3_count", 32'(count), 2);
`endif
        tick();
        repeat (3) begin
            drive(1'b0, '0, '0, 1'b0, 1'b0, 12'h0A0, 12'h0A1);
            tick();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 12'h0A0, 12'h0A1);
        chk("t3_ram_after", 32'(d_out_a), 32'h2222);
        tick();

        // Flush with hold toggling.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, AW'(12'h050 + i), DW'($urandom), 1'b1, 1'b0, 12'h050, 12'h052);
            tick();
        end
        drive(1'b0, '0, '0, 1'b1, 1'b1, 12'h050, 12'h052);
        tick();
        foreach (rv[i]) begin end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 12'h060, DW'($urandom), (i == 1), 1'b0, 12'h051, 12'h060);
            chk("t4_in_ready_low", 32'(in_ready), 0);
            chk("t4_no_done", 32'(flush_done), 0);
            tick();
        end
        idle(1'b0);
        chk("t4_flush_done", 32'(flush_done), 1);
        chk("t4_empty", 32'(empty), 1);
        tick();
        idle(1'b0);
        chk("t4_done_once", 32'(flush_done), 0);
        chk("t4_ready_back", 32'(in_ready), 1);
        tick();

        // Full buffer with continuous traffic: pointers wrap several times.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, AW'(12'h100 + i), DW'($urandom), 1'b1, 1'b0, 12'h100, 12'h200);
            tick();
        end
        drive(1'b1, 12'h200, DW'($urandom), 1'b0, 1'b0, 12'h101, 12'h200);
        chk("t5_first_full", 32'(in_ready), 0);
        tick();
        for (int k = 0; k < 2 * DEPTH + 2; k++) begin
            drive(1'b1, AW'(12'h201 + k), DW'($urandom), 1'b0, 1'b0, AW'(12'h200 + k), 12'h103);
            chk("t5_ready", 32'(in_ready), 1);
            tick();
            chk("t5_count", 32'(count), DEPTH - 1);
        end
        repeat (DEPTH) begin
            idle(1'b0);
            tick();
        end

        // Reset in the middle of a drain.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, AW'(12'h300 + i), DW'($urandom), 1'b1, 1'b0, 12'h300, 12'h301);
            tick();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 12'h300, 12'h301);
        chk("t6_pre_wr", 32'(ram_wr), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_wr_drop", 32'(ram_wr), 0);
        chk("t6_count", 32'(count), 0);
        chk("t6_empty", 32'(empty), 1);
        q.delete();
        phase = 0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) begin
            drive(1'b0, '0, '0, 1'b0, 1'b0, 12'h300, 12'h301);
            chk("t6_no_stale", 32'(ram_wr), 0);
            tick();
        end

        // Random traffic over a small address pool to provoke matches.
        for (int n = 0; n < 800; n++) begin
            drive(($urandom_range(0, 9) < 7), AW'(12'h040 + $urandom_range(0, 7)), DW'($urandom),
                  ($urandom_range(0, 9) < 3), ($urandom_range(0, 29) == 0),
                  AW'(12'h040 + $urandom_range(0, 7)), AW'(12'h040 + $urandom_range(0, 7)));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/ram4k_wr_buffer.md
Name: ram4k_wr_buffer

Overview:
- Write-posting buffer directly upstream of the 4K-word RAM array.
- Accepts write requests through a valid/ready handshake, queues up to DEPTH of them, and drains one per cycle onto the array's single write port.
- Both array read ports pass through this block. Reads to an address with a pending write return the queued data (read-after-write forwarding), so callers always see the latest written value.

Parameters:
- DEPTH, 4, number of queue entries; power of 2, minimum 2.
- AW, 12, address width; matches the 4K-word array.
- DW, 16, data width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset.
- in_valid  in  1  write request valid.
- in_ready  out  1  buffer can accept a request this cycle.
- in_addr  in  AW  write address.
- in_data  in  DW  write data.
- hold  in  1  1 = suppress draining this cycle (array write port busy or owned elsewhere).
- flush  in  1  single-cycle request to drain the buffer completely.
- flush_done  out  1  one-cycle pulse when a flush completes.
- ram_wr  out  1  write enable to the array.
- ram_wr_addr  out  AW  write address to the array.
- ram_d_in  out  DW  write data to the array.
- rd_addr_a  in  AW  read address, port A; passed through to the array.
- rd_addr_b  in  AW  read address, port B; passed through to the array.
- ram_d_out_a  in  DW  array read data, port A (combinational from rd_addr_a).
- ram_d_out_b  in  DW  array read data, port B.
- d_out_a  out  DW  forwarded read data, port A.
- d_out_b  out  DW  forwarded read data, port B.
- count  out  $clog2(DEPTH)+1  number of occupied entries.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.

Behaviour:
- Storage is a circular queue with head and tail pointers and a count register.
  - Reset values: count 0, pointers 0, FSM in RUN, flush_done 0.
  - Entry contents are not reset.
- Push:
  - A push occurs when in_valid && in_ready at the rising edge.
  - in_ready = !full && state==RUN. It is not dependent on in_valid.
- Drain (combinational):
  - ram_wr = !empty && !hold.
  - ram_wr_addr and ram_d_in always show the head entry.
  - The head is popped on the same edge that the array captures the write. Write latency from accepted push to array update is at least 1 cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance. When full, no push is accepted even if a pop occurs that cycle.
- Pointer wrap: pointers wrap at DEPTH-1 to 0.
- Forwarding (combinational):
  - d_out_x = data of the youngest valid entry whose address equals rd_addr_x; otherwise ram_d_out_x.
  - The head entry being written this cycle still forwards. After the edge, the array holds the value.
  - Same-cycle push data is not forwarded; it becomes visible the next cycle.
- FSM states:
  - RUN: if flush=1, go to FLUSH, or go to DONE if already empty.
  - FLUSH: in_ready=0; draining continues but still honours hold. When count becomes 0 (empty next cycle), go to DONE.
  - DONE: flush_done=1 for exactly one cycle; return to RUN.
  - flush asserted outside RUN is ignored.
- Reset asserted mid-operation: all pending entries are discarded, and ram_wr drops to 0 immediately (asynchronously, since count clears).
- Unused in DEPTH==1 configurations; DEPTH<2 is illegal.

Optional Feature:
- Macro: WR_BUFFER_COALESCE_EN.
- Defined:
  - A push whose address matches a valid entry other than the head being popped that cycle overwrites that entry's data in place.
  - count and the tail do not change, and in_ready additionally stays 1 when full if in_addr matches such an entry.
  - Invariant: at most one entry per address.
- Undefined:
  - Every accepted push allocates a new entry; duplicates are allowed.
  - Forwarding picks the youngest matching entry.

Test Plan:
- Reset, then push (0x123,0xBEEF) with hold=0 -> ram_wr=1 on the next cycle with addr 0x123 and data 0xBEEF; count 1 then 0; empty=1 after the pop.
- hold=1, push 4 writes to 0x000..0x003 -> full=1, in_ready=0, and a 5th request stalls. Release hold -> 4 consecutive ram_wr cycles in order 0x000..0x003.
- hold=1, push (0x0A0,0x1111) then (0x0A0,0x2222); rd_addr_a=0x0A0 -> d_out_a=0x2222. rd_addr_b=0x0A1 -> d_out_b=ram_d_out_b.
  - With WR_BUFFER_COALESCE_EN: count=1.
  - Without it: count=2.
- 3 entries pending, pulse flush with hold toggling 1,0,1,0,0 -> in_ready=0 throughout; flush_done pulses one cycle after the last pop; in_ready returns to 1.
- Full buffer with in_valid=1 and hold=0 -> one pop per cycle. No push is accepted on the first full cycle; pushes are accepted thereafter, count stays DEPTH-1, and pointers wrap correctly through more than 2*DEPTH writes.
- Assert reset low mid-drain with 2 entries pending -> ram_wr=0 immediately; count=0 and empty=1. After release, no stale writes are issued.
